// File: rtl/wire_toggle_tx.sv
// wire_toggle_tx: transmitting end of the toggle-wire link.
// Queues trigger requests and turns them into single level changes of
// wire_out, at most one per logic frame (frames are bounded by logic_reset).
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | armed, nothing pending
//   FIRE  | armed, pending > 0; wire_out toggles on the next edge
//   HOLD  | already toggled this frame, waiting for logic_reset
module wire_toggle_tx #(
    parameter int   CNT_W      = 4,
    parameter logic INIT_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             logic_reset,
    input  logic             trig_valid,
    output logic             trig_ready,
    output logic             wire_out,
    output logic             fired,
    output logic [CNT_W-1:0] pending,
    output logic             armed
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] PEND_MAX = '1;
    localparam logic [CNT_W-1:0] PEND_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_wire;
    logic             r_fired;
    logic [CNT_W-1:0] r_pending;
    logic [CNT_W-1:0] w_pending_nxt;
    logic             w_fire_now;
    logic             w_ready;
    logic             w_accept;

    // Handshake and counter update; ready looks only at registered state so a
    // full queue still accepts in the cycle it drains one entry.
    always_comb begin
        w_fire_now    = (r_state == FIRE);
        w_ready       = (r_pending != PEND_MAX) || w_fire_now;
        w_accept      = trig_valid && w_ready;
        w_pending_nxt = r_pending;
        if (w_accept && !w_fire_now) begin
            w_pending_nxt = r_pending + PEND_ONE;
        end else if (!w_accept && w_fire_now) begin
            w_pending_nxt = r_pending - PEND_ONE;
        end
    end

    // Next-state logic; logic_reset only matters while holding.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = FIRE;
                end
            end
            FIRE: begin
                w_state_nxt = HOLD;
            end
            HOLD: begin
                if (logic_reset) begin
                    w_state_nxt = (w_pending_nxt != '0) ? FIRE : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counter and wire level registers; reset discards queued requests.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_wire    <= INIT_LEVEL;
            r_fired   <= 1'b0;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wire    <= r_wire ^ w_fire_now;
            r_fired   <= w_fire_now;
            r_pending <= w_pending_nxt;
        end
    end

    assign trig_ready = w_ready;
    assign wire_out   = r_wire;
    assign fired      = r_fired;
    assign pending    = r_pending;
    assign armed      = (r_state != HOLD);

endmodule
